rf_write_arbiter: RTL and testbench

Write-port arbiter in front of the register file: merges the pipeline writeback, the stall-replay writeback, the UI (interrupt/exception) writeback and the UART receive byte stream onto a single registered write port. It buffers one request per backpressured source, resolves same-register collisions in favour of the pipeline writeback, steers UART bytes alternately into the two UART registers, and prevents starvation of the UART source.

---
 rtl/rf_write_arbiter_if.sv | 48 ++++
 rtl/rf_write_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Source/sink bundle for the register-file write arbiter.
// The master side drives write requests; the slave side is the arbiter.
interface rf_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  logic              ui_valid;
  logic [ADDR_W-1:0] ui_addr;
  logic [DATA_W-1:0] ui_data;
  logic              ui_ready;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rx_sel;
  logic [2:0]        pending;

  modport master (
    output wb_valid, wb_addr, wb_data,
    output st_valid, st_addr, st_data,
    output ui_valid, ui_addr, ui_data,
    output rx_valid, rx_data,
    input  st_ready, ui_ready, rx_ready,
    input  rf_we, rf_waddr, rf_wdata, rx_sel, pending
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  st_valid, st_addr, st_data,
    input  ui_valid, ui_addr, ui_data,
    input  rx_valid, rx_data,
    output st_ready, ui_ready, rx_ready,
    output rf_we, rf_waddr, rf_wdata, rx_sel, pending
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Merges pipeline, stall-replay, UI and UART writebacks onto one registered
// register-file write port, with one holding slot per backpressured source.
module rf_write_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned UART_REG0  = 16,
  parameter int unsigned UART_REG1  = 17,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic             clk,
  input logic             reset,
  rf_write_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [2:0] {
    GNT_NONE = 3'd0,
    GNT_WB   = 3'd1,
    GNT_ST   = 3'd2,
    GNT_UI   = 3'd3,
    GNT_RX   = 3'd4
  } gnt_e;

  logic              r_st_full;
  req_t              r_st;
  logic              r_ui_full;
  req_t              r_ui;
  logic              r_rx_full;
  logic              r_rx_dst;
  logic [7:0]        r_rx_byte;
  logic              r_rx_sel;
  logic [CNT_W-1:0]  r_starve;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;

  logic              w_wb_go;
  logic              w_starved;
  logic [ADDR_W-1:0] w_rx_addr;
  gnt_e              w_gnt;
  logic              w_st_clr;
  logic              w_ui_clr;
  logic              w_rx_clr;
  logic              w_st_keep;
  logic              w_ui_keep;
  logic              w_rx_cap;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_wb_go   = bus.wb_valid && (bus.wb_addr != '0);
  assign w_rx_addr = r_rx_dst ? ADDR_W'(UART_REG1) : ADDR_W'(UART_REG0);
  assign w_starved = r_rx_full && (r_starve >= CNT_W'(STARVE_MAX));

  // Fixed priority; a starved UART byte jumps ahead of st/ui but never wb.
  always_comb begin
    w_gnt = GNT_NONE;
    if (w_wb_go)        w_gnt = GNT_WB;
    else if (w_starved) w_gnt = GNT_RX;
    else if (r_st_full) w_gnt = GNT_ST;
    else if (r_ui_full) w_gnt = GNT_UI;
    else if (r_rx_full) w_gnt = GNT_RX;
  end

  // A held request to the same register as a granted wb is stale: drop it.
  assign w_st_clr = (w_gnt == GNT_ST) ||
                    (w_wb_go && r_st_full && (r_st.addr == bus.wb_addr));
  assign w_ui_clr = (w_gnt == GNT_UI) ||
                    (w_wb_go && r_ui_full && (r_ui.addr == bus.wb_addr));
  assign w_rx_clr = (w_gnt == GNT_RX) ||
                    (w_wb_go && r_rx_full && (w_rx_addr == bus.wb_addr));

  // Zero-register requests complete the handshake but are never stored.
  assign w_st_keep = bus.st_valid && !r_st_full && (bus.st_addr != '0);
  assign w_ui_keep = bus.ui_valid && !r_ui_full && (bus.ui_addr != '0);
  assign w_rx_cap  = bus.rx_valid && !r_rx_full;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    case (w_gnt)
      GNT_WB: begin
        w_we    = 1'b1;
        w_waddr = bus.wb_addr;
        w_wdata = bus.wb_data;
      end
      GNT_ST: begin
        w_we    = 1'b1;
        w_waddr = r_st.addr;
        w_wdata = r_st.data;
      end
      GNT_UI: begin
        w_we    = 1'b1;
        w_waddr = r_ui.addr;
        w_wdata = r_ui.data;
      end
      GNT_RX: begin
        w_we    = 1'b1;
        w_waddr = w_rx_addr;
        w_wdata = DATA_W'(r_rx_byte);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st_full <= 1'b0;
      r_st      <= '0;
    end else if (w_st_keep) begin
      r_st_full <= 1'b1;
      r_st      <= '{addr: bus.st_addr, data: bus.st_data};
    end else if (w_st_clr) begin
      r_st_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ui_full <= 1'b0;
      r_ui      <= '0;
    end else if (w_ui_keep) begin
      r_ui_full <= 1'b1;
      r_ui      <= '{addr: bus.ui_addr, data: bus.ui_data};
    end else if (w_ui_clr) begin
      r_ui_full <= 1'b0;
    end
  end

  // UART slot latches its destination at capture; rx_sel flips per byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_full <= 1'b0;
      r_rx_dst  <= 1'b0;
      r_rx_byte <= '0;
      r_rx_sel  <= 1'b0;
    end else if (w_rx_cap) begin
      r_rx_full <= 1'b1;
      r_rx_dst  <= r_rx_sel;
      r_rx_byte <= bus.rx_data;
      r_rx_sel  <= ~r_rx_sel;
    end else if (w_rx_clr) begin
      r_rx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (!r_rx_full || w_rx_clr) begin
      r_starve <= '0;
    end else if (r_starve != '1) begin
      r_starve <= r_starve + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_we;
      if (w_we) begin
        r_rf_waddr <= w_waddr;
        r_rf_wdata <= w_wdata;
      end
    end
  end

  assign bus.st_ready = ~r_st_full;
  assign bus.ui_ready = ~r_ui_full;
  assign bus.rx_ready = ~r_rx_full;
  assign bus.rf_we    = r_rf_we;
  assign bus.rf_waddr = r_rf_waddr;
  assign bus.rf_wdata = r_rf_wdata;
  assign bus.rx_sel   = r_rx_sel;
  assign bus.pending  = {r_rx_full, r_ui_full, r_st_full};

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a per-cycle source/priority model
// queues expected writes, a monitor pops them as the DUT writes.
module tb_rf_write_arbiter;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned UART_REG0  = 16;
  localparam int unsigned UART_REG1  = 17;
  localparam int unsigned STARVE_MAX = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .UART_REG0(UART_REG0),
    .UART_REG1(UART_REG1), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  uart_wr_cyc = -1;

  // Reference: sources 0=st, 1=ui, 2=rx, each holding at most one request.
  bit                m_full[3];
  logic [ADDR_W-1:0] m_addr[3];
  logic [DATA_W-1:0] m_data[3];
  bit                m_sel;
  int                m_wait;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    m_sel  = 1'b0;
    m_wait = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ui_valid = 1'b0; bus.ui_addr = '0; bus.ui_data = '0;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
  endtask

  // Check visible state, advance the model by one clock, then clock the DUT.
  task automatic tick();
    int  win;
    bit  rdy[3];
    bit  drop;
    check("st_ready", 64'(bus.st_ready), 64'(!m_full[0]));
    check("ui_ready", 64'(bus.ui_ready), 64'(!m_full[1]));
    check("rx_ready", 64'(bus.rx_ready), 64'(!m_full[2]));
    check("pending", 64'(bus.pending), 64'({m_full[2], m_full[1], m_full[0]}));
    check("rx_sel", 64'(bus.rx_sel), 64'(m_sel));

    win = -1;
    if (bus.wb_valid && bus.wb_addr != '0) win = 3;
    else if (m_full[2] && m_wait >= int'(STARVE_MAX)) win = 2;
    else for (int i = 0; i < 3; i++) if (win < 0 && m_full[i]) win = i;

    if (win == 3) exp_q.push_back('{addr: bus.wb_addr, data: bus.wb_data});
    else if (win >= 0) exp_q.push_back('{addr: m_addr[win], data: m_data[win]});

    for (int i = 0; i < 3; i++) begin
      rdy[i] = !m_full[i];
      drop = (win == i) || (win == 3 && m_full[i] && m_addr[i] == bus.wb_addr);
      if (i == 2) m_wait = (m_full[2] && !drop) ? m_wait + 1 : 0;
      if (drop) m_full[i] = 1'b0;
    end

    if (bus.st_valid && rdy[0] && bus.st_addr != '0) begin
      m_full[0] = 1'b1; m_addr[0] = bus.st_addr; m_data[0] = bus.st_data;
    end
    if (bus.ui_valid && rdy[1] && bus.ui_addr != '0) begin
      m_full[1] = 1'b1; m_addr[1] = bus.ui_addr; m_data[1] = bus.ui_data;
    end
    if (bus.rx_valid && rdy[2]) begin
      m_full[2] = 1'b1;
      m_addr[2] = m_sel ? ADDR_W'(UART_REG1) : ADDR_W'(UART_REG0);
      m_data[2] = DATA_W'(bus.rx_data);
      m_sel     = ~m_sel;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every DUT write must match the oldest expected write.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (reset && bus.rf_we) begin
      if (bus.rf_waddr == ADDR_W'(UART_REG0) || bus.rf_waddr == ADDR_W'(UART_REG1))
        uart_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg%0d=0x%0h expected no write (t=%0t)",
                 bus.rf_waddr, bus.rf_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("rf_waddr", 64'(bus.rf_waddr), 64'(e.addr));
        check("rf_wdata", 64'(bus.rf_wdata), 64'(e.data));
      end
    end
  end

  function automatic logic [ADDR_W-1:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r <= 2) return ADDR_W'(UART_REG0 + $urandom_range(0, 1));
    return ADDR_W'($urandom_range(1, 6));
  endfunction

  initial begin
    int cap_cyc;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_rf_we", 64'(bus.rf_we), 64'(0));
    check("reset_rf_waddr", 64'(bus.rf_waddr), 64'(0));
    check("reset_rf_wdata", 64'(bus.rf_wdata), 64'(0));
    reset = 1'b1;
    tick();

    // Priority: wb, then st, then ui on consecutive cycles.
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hA;
    bus.st_valid = 1'b1; bus.st_addr = 5'd6; bus.st_data = 32'hB;
    bus.ui_valid = 1'b1; bus.ui_addr = 5'd7; bus.ui_data = 32'hC;
    tick();
    idle_inputs();
    repeat (3) tick();

    // Collision: held st(9) is overwritten by wb(9).
    bus.st_valid = 1'b1; bus.st_addr = 5'd9; bus.st_data = 32'h11;
    tick();
    idle_inputs();
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h22;
    tick();
    idle_inputs();
    repeat (2) tick();

    // UART steering alternates between the two UART registers.
    for (int b = 0; b < 3; b++) begin
      bus.rx_valid = 1'b1; bus.rx_data = 8'(8'h41 + b);
      tick();
      idle_inputs();
      repeat (2) tick();
    end
    check("rx_sel_after_3", 64'(bus.rx_sel), 64'(1));

    // Starvation: st/ui refilled whenever ready while one rx byte waits.
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    bus.st_valid = 1'b1; bus.st_addr = 5'd3;
    bus.ui_valid = 1'b1; bus.ui_addr = 5'd4;
    uart_wr_cyc = -1;
    cap_cyc = cyc + 1;
    for (int i = 0; i < 20; i++) begin
      bus.st_data = $urandom;
      bus.ui_data = $urandom;
      tick();
      bus.rx_valid = 1'b0;
    end
    idle_inputs();
    repeat (3) tick();
    checks++;
    if (uart_wr_cyc < 0 || uart_wr_cyc - cap_cyc > int'(STARVE_MAX) + 1 ||
        uart_wr_cyc <= cap_cyc) begin
      errors++;
      $display("FAIL starve_latency: got %0d cycles expected 1..%0d",
               uart_wr_cyc - cap_cyc, STARVE_MAX + 1);
    end

    // Zero register: accepted but never written.
    bus.st_valid = 1'b1; bus.st_addr = 5'd0; bus.st_data = 32'hFF;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1;
    tick();
    idle_inputs();
    repeat (3) tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bus.wb_valid = ($urandom_range(0, 9) < 3);
      bus.wb_addr  = rnd_addr();
      bus.wb_data  = $urandom;
      bus.st_valid = ($urandom_range(0, 1) == 1);
      bus.st_addr  = rnd_addr();
      bus.st_data  = $urandom;
      bus.ui_valid = ($urandom_range(0, 1) == 1);
      bus.ui_addr  = rnd_addr();
      bus.ui_data  = $urandom;
      bus.rx_valid = ($urandom_range(0, 2) == 0);
      bus.rx_data  = 8'($urandom);
      tick();
    end

    // Reset mid-burst discards everything immediately.
    bus.st_valid = 1'b1; bus.st_addr = 5'd2; bus.st_data = 32'h77;
    bus.ui_valid = 1'b1; bus.ui_addr = 5'd3; bus.ui_data = 32'h88;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h99;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h66;
    repeat (2) tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_rf_we", 64'(bus.rf_we), 64'(0));
    check("midrst_pending", 64'(bus.pending), 64'(0));
    check("midrst_ready", 64'({bus.rx_ready, bus.ui_ready, bus.st_ready}), 64'(3'b111));
    check("midrst_rx_sel", 64'(bus.rx_sel), 64'(0));
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h31;
    tick();
    idle_inputs();
    repeat (4) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
